// File: rtl/riscv_issue_ctrl.sv
// Issue/hazard controller in front of riscv_ex: one-per-cycle issue, per-register load
// scoreboard for load-use stalls, registered forwarding selects and a saturating stall counter.
module riscv_issue_ctrl #(
  parameter int REGA   = 5,
  parameter int MEMLAT = 2,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [REGA-1:0] id_rs1,
  input  logic [REGA-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [REGA-1:0] id_rd,
  input  logic            id_we,
  input  logic            id_is_load,
  input  logic            flush,
  output logic            ex_valid,
  output logic [REGA-1:0] ex_rdi,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic [CNTW-1:0] stall_cnt
);

  localparam int NREG = 1 << REGA;
  localparam int LW   = (MEMLAT < 1) ? 1 : $clog2(MEMLAT + 1);

  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_EX = 2'd1;
  localparam logic [1:0] SEL_WB = 2'd2;

  logic [LW-1:0]   lcnt [NREG];

  logic            ex_we;
  logic            ex_load;
  logic            wb_valid;
  logic [REGA-1:0] wb_rd;
  logic            wb_we;
  logic            wb_load;

  logic            busy_rs1;
  logic            busy_rs2;
  logic            hazard;
  logic            issue;
  logic            load_set;
  logic            stall_now;
  logic [1:0]      fwd_a_nxt;
  logic [1:0]      fwd_b_nxt;

  // A source is blocked while a load to it has not yet reached the regfile.
  always_comb begin
    busy_rs1  = id_use_rs1 && (id_rs1 != '0) && (lcnt[id_rs1] != '0);
    busy_rs2  = id_use_rs2 && (id_rs2 != '0) && (lcnt[id_rs2] != '0);
    hazard    = busy_rs1 || busy_rs2;
    id_ready  = ~hazard;
    issue     = id_valid && id_ready && !flush;
    load_set  = issue && id_is_load && id_we && (id_rd != '0);
    stall_now = id_valid && !id_ready && !flush;
  end

  // Loaded values never come from a forwarding path; only ALU results in EX/WB qualify.
  always_comb begin
    fwd_a_nxt = SEL_RF;
    fwd_b_nxt = SEL_RF;
    if (issue && id_use_rs1 && (id_rs1 != '0)) begin
      if (ex_valid && ex_we && !ex_load && (ex_rdi == id_rs1)) begin
        fwd_a_nxt = SEL_EX;
      end else if (wb_valid && wb_we && !wb_load && (wb_rd == id_rs1)) begin
        fwd_a_nxt = SEL_WB;
      end
    end
    if (issue && id_use_rs2 && (id_rs2 != '0)) begin
      if (ex_valid && ex_we && !ex_load && (ex_rdi == id_rs2)) begin
        fwd_b_nxt = SEL_EX;
      end else if (wb_valid && wb_we && !wb_load && (wb_rd == id_rs2)) begin
        fwd_b_nxt = SEL_WB;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_rdi   <= '0;
      ex_we    <= 1'b0;
      ex_load  <= 1'b0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_we    <= 1'b0;
      wb_load  <= 1'b0;
      fwd_a    <= SEL_RF;
      fwd_b    <= SEL_RF;
    end else begin
      ex_valid <= issue;
      ex_rdi   <= issue ? id_rd : '0;
      ex_we    <= issue && id_we;
      ex_load  <= issue && id_is_load;
      wb_valid <= ex_valid;
      wb_rd    <= ex_rdi;
      wb_we    <= ex_we;
      wb_load  <= ex_load;
      fwd_a    <= fwd_a_nxt;
      fwd_b    <= fwd_b_nxt;
    end
  end

  // A new load restarts its register's countdown even if one is already pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        lcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (load_set && (id_rd == REGA'(i))) begin
          lcnt[i] <= LW'(MEMLAT);
        end else if (lcnt[i] != '0) begin
          lcnt[i] <= lcnt[i] - LW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_now && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule
